// File: rtl/scan_test_pkg.sv
// Shared types and constants for the scan test controller: FSM state encoding
// plus the signature-register polynomial, seed and single-step helper.
package scan_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    UNLOAD,
    DONE
  } state_e;

  // x^16 + x^12 + x^5 + 1, left-shifting Galois form
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  function automatic logic [15:0] misr_step(input logic [15:0] cur, input logic din);
    misr_step = {cur[14:0], 1'b0} ^ (cur[15] ? MISR_POLY : 16'h0000) ^ {15'b0, din};
  endfunction

endpackage

// File: rtl/scan_shift_cmp.sv
// Stimulus PISO plus serial response comparator; the same datapath serves
// both the overlapped load/unload pass and the final unload-only pass.
module scan_shift_cmp #(
  parameter int CHAIN_LEN = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 cmp_en,
  input  logic [CHAIN_LEN-1:0] stim_in,
  input  logic [CHAIN_LEN-1:0] exp_in,
  input  logic                 scan_si,
  output logic                 so_bit,
  output logic                 fail_next
);

  logic [CHAIN_LEN-1:0] stim_q, stim_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic                 fail_q, fail_d;

  // A load starts a fresh pass, so the accumulator is cleared alongside it.
  always_comb begin
    stim_d = stim_q;
    exp_d  = exp_q;
    fail_d = fail_q;
    if (load) begin
      stim_d = stim_in;
      exp_d  = exp_in;
      fail_d = 1'b0;
    end else if (shift) begin
      stim_d = stim_q >> 1;
      exp_d  = exp_q >> 1;
      fail_d = fail_q | (cmp_en & (scan_si ^ exp_q[0]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stim_q <= '0;
      exp_q  <= '0;
      fail_q <= 1'b0;
    end else begin
      stim_q <= stim_d;
      exp_q  <= exp_d;
      fail_q <= fail_d;
    end
  end

  assign so_bit    = stim_q[0];
  assign fail_next = fail_d;

endmodule

// File: rtl/scan_test_ctrl.sv
// Scan test initiator: shifts patterns in, captures, unloads and compares responses.
// Optional MISR signature output enabled by defining SCAN_TEST_CTRL_MISR_EN.
module scan_test_ctrl
  import scan_test_pkg::*;
#(
  parameter int CHAIN_LEN = 5,
  parameter int CNT_W     = 16
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 Pat_valid,
  output logic                 Pat_ready,
  input  logic [CHAIN_LEN-1:0] Pat_data,
  input  logic [CHAIN_LEN-1:0] Exp_data,
  input  logic                 Pat_last,
  output logic                 Scan_en,
  output logic                 Scan_so,
  input  logic                 Scan_si,
  output logic                 Res_valid,
  output logic                 Res_fail,
  output logic [CNT_W-1:0]     Fail_cnt,
  output logic                 Busy
`ifdef SCAN_TEST_CTRL_MISR_EN
  ,
  output logic [15:0]          Signature
`endif
);

  localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 have_prev_q, have_prev_d;
  logic [CHAIN_LEN-1:0] exp_cur_q, exp_cur_d;
  logic                 last_q, last_d;
  logic                 res_valid_q, res_valid_d;
  logic                 res_fail_q, res_fail_d;
  logic [CNT_W-1:0]     fail_cnt_q, fail_cnt_d;

  logic                 ld, sh, cmp_en;
  logic [CHAIN_LEN-1:0] ld_stim;
  logic                 scan_en, scan_so, pat_ready;
  logic                 so_bit, fail_next;

  scan_shift_cmp #(
    .CHAIN_LEN(CHAIN_LEN)
  ) u_shift_cmp (
    .clk      (Clock),
    .rst_n    (Reset_n),
    .load     (ld),
    .shift    (sh),
    .cmp_en   (cmp_en),
    .stim_in  (ld_stim),
    .exp_in   (exp_cur_q),
    .scan_si  (Scan_si),
    .so_bit   (so_bit),
    .fail_next(fail_next)
  );

  // Leaving CAPTURE reloads the comparator with the just-captured pattern's
  // expected data, which is how "current" becomes "previous".
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    have_prev_d = have_prev_q;
    exp_cur_d   = exp_cur_q;
    last_d      = last_q;
    res_valid_d = 1'b0;
    res_fail_d  = 1'b0;
    ld          = 1'b0;
    sh          = 1'b0;
    cmp_en      = 1'b0;
    ld_stim     = Pat_data;
    scan_en     = 1'b0;
    scan_so     = 1'b0;
    pat_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        pat_ready = 1'b1;
        if (Pat_valid) begin
          ld          = 1'b1;
          exp_cur_d   = Exp_data;
          last_d      = Pat_last;
          have_prev_d = 1'b0;
          bit_cnt_d   = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        scan_en = 1'b1;
        scan_so = so_bit;
        sh      = 1'b1;
        cmp_en  = have_prev_q;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d   = '0;
          state_d     = CAPTURE;
          res_valid_d = have_prev_q;
          res_fail_d  = have_prev_q & fail_next;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        have_prev_d = 1'b1;
        if (last_q) begin
          ld        = 1'b1;
          ld_stim   = '0;
          bit_cnt_d = '0;
          state_d   = UNLOAD;
        end else begin
          pat_ready = 1'b1;
          if (Pat_valid) begin
            ld        = 1'b1;
            exp_cur_d = Exp_data;
            last_d    = Pat_last;
            bit_cnt_d = '0;
            state_d   = SHIFT;
          end
        end
      end
      UNLOAD: begin
        scan_en = 1'b1;
        sh      = 1'b1;
        cmp_en  = 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d   = '0;
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_fail_d  = fail_next;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DONE: begin
        have_prev_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fail_cnt_d = fail_cnt_q;
    if (res_valid_q && res_fail_q && !(&fail_cnt_q)) begin
      fail_cnt_d = fail_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      have_prev_q <= 1'b0;
      exp_cur_q   <= '0;
      last_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_fail_q  <= 1'b0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      have_prev_q <= have_prev_d;
      exp_cur_q   <= exp_cur_d;
      last_q      <= last_d;
      res_valid_q <= res_valid_d;
      res_fail_q  <= res_fail_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

`ifdef SCAN_TEST_CTRL_MISR_EN
  logic [15:0] misr_q, misr_d;

  always_comb begin
    misr_d = misr_q;
    if (cmp_en) begin
      misr_d = misr_step(misr_q, Scan_si);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      misr_q <= MISR_SEED;
    end else begin
      misr_q <= misr_d;
    end
  end

  assign Signature = misr_q;
`endif

  // Pat_ready is forced low while reset is held, even though the state is IDLE.
  assign Pat_ready = pat_ready & Reset_n;
  assign Scan_en   = scan_en;
  assign Scan_so   = scan_so;
  assign Res_valid = res_valid_q;
  assign Res_fail  = res_fail_q;
  assign Fail_cnt  = fail_cnt_q;
  assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Scoreboard bench for scan_test_ctrl with a 5-flop echo chain model
// (captured response equals loaded stimulus).
module tb_scan_test_ctrl;

  localparam int CL = 5;

  logic          clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Pat_valid = 1'b0;
  logic [CL-1:0] Pat_data = '0;
  logic [CL-1:0] Exp_data = '0;
  logic          Pat_last = 1'b0;
  logic          Pat_ready, Scan_en, Scan_so, Scan_si;
  logic          Res_valid, Res_fail, Busy;
  logic [1:0]    Fail_cnt;
`ifdef SCAN_TEST_CTRL_MISR_EN
  logic [15:0]   Signature;
`endif

  scan_test_ctrl #(.CHAIN_LEN(CL), .CNT_W(2)) dut (
    .Clock    (clk),
    .Reset_n  (Reset_n),
    .Pat_valid(Pat_valid),
    .Pat_ready(Pat_ready),
    .Pat_data (Pat_data),
    .Exp_data (Exp_data),
    .Pat_last (Pat_last),
    .Scan_en  (Scan_en),
    .Scan_so  (Scan_so),
    .Scan_si  (Scan_si),
    .Res_valid(Res_valid),
    .Res_fail (Res_fail),
    .Fail_cnt (Fail_cnt),
    .Busy     (Busy)
`ifdef SCAN_TEST_CTRL_MISR_EN
    ,
    .Signature(Signature)
`endif
  );

  always #5 clk = ~clk;

  logic [CL-1:0] chain = '0;
  always @(posedge clk) if (Scan_en) chain <= {chain[CL-2:0], Scan_so};
  assign Scan_si = chain[CL-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int res_cnt = 0;
  int res_cyc = 0;
  int acc_cyc = 0;
  bit exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (Res_valid) begin
      res_cnt++;
      res_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL res_unexpected: got Res_valid with Res_fail=%0b, expected none", Res_fail);
      end else begin
        check("res_fail", {31'b0, Res_fail}, {31'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [CL-1:0] pat, input logic [CL-1:0] ex,
                      input logic last, input bit efail, input bit push);
    int t;
    if (push) exp_q.push_back(efail);
    @(negedge clk);
    Pat_valid = 1'b1;
    Pat_data  = pat;
    Exp_data  = ex;
    Pat_last  = last;
    t = 0;
    while (!Pat_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      check("send_timeout", 32'd1, 32'd0);
      Pat_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1 Pat_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (Busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset_n = 1'b0;
    repeat (2) @(negedge clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int so_ref [5] = '{0, 1, 1, 0, 1};
    int rc;
    int low;
    int t;

    // Reset values while reset is held
    repeat (2) @(negedge clk);
    check("rst_scan_en",   {31'b0, Scan_en},   32'd0);
    check("rst_scan_so",   {31'b0, Scan_so},   32'd0);
    check("rst_pat_ready", {31'b0, Pat_ready}, 32'd0);
    check("rst_res_valid", {31'b0, Res_valid}, 32'd0);
    check("rst_res_fail",  {31'b0, Res_fail},  32'd0);
    check("rst_fail_cnt",  {30'b0, Fail_cnt},  32'd0);
    check("rst_busy",      {31'b0, Busy},      32'd0);
    Reset_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'b0, Pat_ready}, 32'd1);

    // Single pattern, matching response
    rc = res_cnt;
    send(5'b10110, 5'b10110, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("shift_en", {31'b0, Scan_en}, 32'd1);
      check("shift_so", {31'b0, Scan_so}, so_ref[i]);
    end
    wait_idle();
    check("single_count",   res_cnt - rc,      32'd1);
    check("single_latency", res_cyc - acc_cyc, 32'd12);
    check("single_failcnt", {30'b0, Fail_cnt}, 32'd0);

    // Three back-to-back, middle expected bit 2 flipped
    rc = res_cnt;
    send(5'b10110, 5'b10110, 1'b0, 1'b0, 1'b1);
    send(5'b01101, 5'b01001, 1'b0, 1'b1, 1'b1);
    send(5'b11001, 5'b11001, 1'b1, 1'b0, 1'b1);
    wait_idle();
    check("b2b_count",   res_cnt - rc,      32'd3);
    check("b2b_failcnt", {30'b0, Fail_cnt}, 32'd1);

    // Pattern withheld four cycles in CAPTURE
    do_reset();
    rc = res_cnt;
    send(5'b00111, 5'b00101, 1'b0, 1'b1, 1'b1);
    t = 0;
    @(negedge clk);
    while (!(Busy && !Scan_en) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("capture_timeout", 32'd1, 32'd0);
    low = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (Busy && !Scan_en) low++;
    end
    exp_q.push_back(1'b0);
    Pat_valid = 1'b1;
    Pat_data  = 5'b11000;
    Exp_data  = 5'b11000;
    Pat_last  = 1'b1;
    @(posedge clk);
    #1 Pat_valid = 1'b0;
    @(negedge clk);
    check("stall_low_cycles", low, 32'd5);
    check("stall_resume_en", {31'b0, Scan_en}, 32'd1);
    wait_idle();
    check("stall_count",   res_cnt - rc,      32'd2);
    check("stall_failcnt", {30'b0, Fail_cnt}, 32'd1);

    // Fail counter saturation with a 2-bit counter
    do_reset();
    send(5'b00001, 5'b00000, 1'b0, 1'b1, 1'b1);
    send(5'b00010, 5'b00000, 1'b0, 1'b1, 1'b1);
    send(5'b00100, 5'b00000, 1'b0, 1'b1, 1'b1);
    send(5'b01000, 5'b00000, 1'b1, 1'b1, 1'b1);
    wait_idle();
    check("sat_failcnt", {30'b0, Fail_cnt}, 32'd3);

    // Reset during the third shift cycle aborts without a result
    send(5'b11111, 5'b11111, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_pre_en", {31'b0, Scan_en}, 32'd1);
    Reset_n = 1'b0;
    @(negedge clk);
    check("abort_scan_en",   {31'b0, Scan_en},   32'd0);
    check("abort_busy",      {31'b0, Busy},      32'd0);
    check("abort_pat_ready", {31'b0, Pat_ready}, 32'd0);
    Reset_n = 1'b1;
    @(negedge clk);
    check("abort_idle_ready", {31'b0, Pat_ready}, 32'd1);
    rc = res_cnt;
    repeat (20) @(negedge clk);
    check("abort_no_result", res_cnt - rc, 32'd0);

`ifdef SCAN_TEST_CTRL_MISR_EN
    // Five zero bits from seed FFFF: EFDF, CF9F, 8F1F, 0E1F, 1C3E
    do_reset();
    send(5'b00000, 5'b00000, 1'b1, 1'b0, 1'b1);
    wait_idle();
    check("misr_signature", {16'b0, Signature}, 32'h1C3E);
`endif

    check("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
